// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decode-side control inputs and
// the registered pc/instruction/valid/halted presentation to decode.
interface instruction_fetch_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
);
  logic                   stall;
  logic                   branch_taken;
  logic [PC_WIDTH-1:0]    branch_target;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   valid;
  logic                   halted;

  // The fetch unit itself
  modport master (
    input  stall, branch_taken, branch_target, imem_rdata,
    output imem_addr, pc, instruction, valid, halted
  );

  // Memory plus decode side seen from outside the fetch unit
  modport slave (
    output stall, branch_taken, branch_target, imem_rdata,
    input  imem_addr, pc, instruction, valid, halted
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage. Issues addresses to a 1-cycle-latency synchronous
// instruction memory and registers the returned word together with the PC it
// belongs to. Supports decode stall, branch redirect with flush, halt on a
// dedicated encoding, and PC wrap-around modulo 2^PC_WIDTH.
module instruction_fetch_unit #(
  parameter int                     PC_WIDTH    = 8,
  parameter int                     INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = '1
) (
  input  logic                       clk,
  input  logic                       reset,
  instruction_fetch_unit_if.master   bus
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  // Issue side: next address to fetch and the address issued last cycle
  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [PC_WIDTH-1:0]    req_pc;
  logic                   req_valid;
  // Presentation side towards decode
  logic [PC_WIDTH-1:0]    pc_p1;
  logic [INSTR_WIDTH-1:0] instr_p1;
  logic                   vld_p1;
  logic                   halted_p1;
  logic [PC_WIDTH-1:0]    addr;
  logic                   halt_hit;

  // Sequential successor; natural overflow gives the wrap to address 0
  function automatic logic [PC_WIDTH-1:0] next_pc(input logic [PC_WIDTH-1:0] a);
    return a + PC_ONE;
  endfunction

  // Halt is recognised only on a word that was really requested
  assign halt_hit = req_valid && (bus.imem_rdata == HALT_INSTR);

  // Address mux: a stall re-reads req_pc so the word on imem_rdata next
  // cycle still matches req_pc and nothing is lost or duplicated
  always_comb begin
    addr = fetch_pc;
    if (reset) begin
      addr = RESET_PC;
    end else if (bus.branch_taken) begin
      addr = bus.branch_target;
    end else if (bus.stall) begin
      addr = req_pc;
    end
  end

  assign bus.imem_addr   = addr;
  assign bus.pc          = pc_p1;
  assign bus.instruction = instr_p1;
  assign bus.valid       = vld_p1;
  assign bus.halted      = halted_p1;

  // Fetch state and output registers; priority reset > branch > stall > halted
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      req_valid <= 1'b0;
      pc_p1     <= '0;
      instr_p1  <= '0;
      vld_p1    <= 1'b0;
      halted_p1 <= 1'b0;
    end else if (bus.branch_taken) begin
      // Redirect: the target is being read this cycle, flush the output
      req_pc    <= bus.branch_target;
      req_valid <= 1'b1;
      fetch_pc  <= next_pc(bus.branch_target);
      vld_p1    <= 1'b0;
      halted_p1 <= 1'b0;
    end else if (!bus.stall) begin
      if (halted_p1) begin
        // Fetching stopped: keep addresses, present nothing further
        req_valid <= 1'b0;
        vld_p1    <= 1'b0;
      end else begin
        // ---- issue stage -> request stage ----
        req_pc    <= fetch_pc;
        req_valid <= 1'b1;
        fetch_pc  <= next_pc(fetch_pc);
        // ---- request stage -> presentation stage ----
        pc_p1     <= req_pc;
        instr_p1  <= bus.imem_rdata;
        vld_p1    <= req_valid;
        if (halt_hit) begin
          halted_p1 <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: an 8-bit-PC instance covers
// latency, stall, branch (with and without stall), wrap via branch, mid-stream
// reset and halt; a 3-bit-PC instance covers free-running wrap.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  logic reset3;
  logic halt_en;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] sb_q[$];
  logic [2:0]  q3[$];

  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) if8();
  instruction_fetch_unit_if #(.PC_WIDTH(3), .INSTR_WIDTH(16)) if3();

  instruction_fetch_unit #(
    .PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'd0), .HALT_INSTR(16'hFFFF)
  ) dut8 (
    .clk(clk), .reset(reset), .bus(if8.master)
  );

  instruction_fetch_unit #(
    .PC_WIDTH(3), .INSTR_WIDTH(16), .RESET_PC(3'd0), .HALT_INSTR(16'hFFFF)
  ) dut3 (
    .clk(clk), .reset(reset3), .bus(if3.master)
  );

  // Synchronous-read memories: rdata = {8'hA0, addr}, optional halt word at 4
  always @(posedge clk) begin
    if8.imem_rdata <= (halt_en && if8.imem_addr == 8'd4) ? 16'hFFFF : {8'hA0, if8.imem_addr};
    if3.imem_rdata <= {8'hA0, 5'd0, if3.imem_addr};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected presentations for a run of sequential PCs starting at start
  task automatic push_seq(input logic [7:0] start, input int n);
    logic [7:0]  a;
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      a = start + 8'(i);
      w = (halt_en && a == 8'd4) ? 16'hFFFF : {8'hA0, a};
      sb_q.push_back({a, w});
    end
  endtask

  // One clock; a fresh valid presentation (not a stall hold) is scored
  task automatic step();
    logic        hold;
    logic [23:0] e;
    hold = if8.stall && !if8.branch_taken && !reset;
    @(posedge clk);
    #1;
    if (if8.valid && !hold) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pc", 32'(if8.pc), 32'(e[23:16]));
        chk("sb_instr", 32'(if8.instruction), 32'(e[15:0]));
      end
    end
  endtask

  task automatic run_valid(input int n, input string tag);
    repeat (n) begin
      step();
      chk(tag, 32'(if8.valid), 32'd1);
    end
  endtask

  initial begin
    logic [2:0] e3;
    reset = 1'b1;
    reset3 = 1'b1;
    halt_en = 1'b0;
    if8.stall = 1'b0;
    if8.branch_taken = 1'b0;
    if8.branch_target = 8'd0;
    if3.stall = 1'b0;
    if3.branch_taken = 1'b0;
    if3.branch_target = 3'd0;

    // Reset state
    repeat (2) step();
    chk("rst_valid", 32'(if8.valid), 32'd0);
    chk("rst_pc", 32'(if8.pc), 32'd0);
    chk("rst_instr", 32'(if8.instruction), 32'd0);
    chk("rst_halted", 32'(if8.halted), 32'd0);
    chk("rst_addr", 32'(if8.imem_addr), 32'd0);

    // Power-up latency and sequential run 0..5
    reset = 1'b0;
    push_seq(8'd0, 10);
    step();
    chk("lat_valid", 32'(if8.valid), 32'd0);
    run_valid(6, "run_valid");

    // Stall 3 cycles while pc=5 is presented
    if8.stall = 1'b1;
    repeat (3) begin
      step();
      chk("stall_pc", 32'(if8.pc), 32'h05);
      chk("stall_instr", 32'(if8.instruction), 32'hA005);
      chk("stall_valid", 32'(if8.valid), 32'd1);
    end
    if8.stall = 1'b0;
    run_valid(4, "post_stall_valid");
    chk("sb_drain_stall", 32'(sb_q.size()), 32'd0);

    // Branch to 0x40 from pc=9
    if8.branch_taken = 1'b1;
    if8.branch_target = 8'h40;
    #1;
    chk("br_addr", 32'(if8.imem_addr), 32'h40);
    push_seq(8'h40, 4);
    step();
    chk("br_flush_valid", 32'(if8.valid), 32'd0);
    chk("br_flush_pc", 32'(if8.pc), 32'h09);
    if8.branch_taken = 1'b0;
    run_valid(4, "br_valid");
    chk("sb_drain_br", 32'(sb_q.size()), 32'd0);

    // Branch with stall also high, to 0xFE so the run wraps to 0
    if8.branch_taken = 1'b1;
    if8.stall = 1'b1;
    if8.branch_target = 8'hFE;
    #1;
    chk("brs_addr", 32'(if8.imem_addr), 32'hFE);
    push_seq(8'hFE, 4);
    step();
    chk("brs_flush_valid", 32'(if8.valid), 32'd0);
    chk("brs_flush_pc", 32'(if8.pc), 32'h43);
    if8.branch_taken = 1'b0;
    if8.stall = 1'b0;
    run_valid(4, "wrap8_valid");
    chk("sb_drain_wrap", 32'(sb_q.size()), 32'd0);

    // Get to pc=9, then a one-cycle reset mid-stream
    if8.branch_taken = 1'b1;
    if8.branch_target = 8'h05;
    push_seq(8'h05, 5);
    step();
    if8.branch_taken = 1'b0;
    run_valid(5, "pre_mr_valid");
    chk("sb_drain_mr", 32'(sb_q.size()), 32'd0);
    reset = 1'b1;
    step();
    chk("mr_valid", 32'(if8.valid), 32'd0);
    chk("mr_pc", 32'(if8.pc), 32'd0);
    chk("mr_instr", 32'(if8.instruction), 32'd0);

    // Restart with the halt word at address 4
    halt_en = 1'b1;
    reset = 1'b0;
    push_seq(8'd0, 5);
    step();
    chk("mr_lat_valid", 32'(if8.valid), 32'd0);
    run_valid(5, "halt_run_valid");
    chk("halt_set", 32'(if8.halted), 32'd1);
    chk("sb_drain_halt", 32'(sb_q.size()), 32'd0);
    repeat (4) begin
      step();
      chk("halt_valid", 32'(if8.valid), 32'd0);
      chk("halt_flag", 32'(if8.halted), 32'd1);
      chk("halt_addr", 32'(if8.imem_addr), 32'd6);
    end

    // Branch out of halt
    if8.branch_taken = 1'b1;
    if8.branch_target = 8'd0;
    push_seq(8'd0, 2);
    step();
    chk("hx_halted", 32'(if8.halted), 32'd0);
    chk("hx_valid", 32'(if8.valid), 32'd0);
    if8.branch_taken = 1'b0;
    run_valid(2, "hx_valid_run");
    chk("sb_drain_hx", 32'(sb_q.size()), 32'd0);
    reset = 1'b1;
    step();

    // 3-bit PC instance: free run across the wrap
    reset3 = 1'b0;
    for (int k = 0; k < 10; k++) q3.push_back(3'(k));
    step();
    chk("w3_lat_valid", 32'(if3.valid), 32'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("w3_valid", 32'(if3.valid), 32'd1);
      e3 = q3.pop_front();
      chk("w3_pc", 32'(if3.pc), 32'(e3));
      chk("w3_instr", 32'(if3.instruction), 32'({8'hA0, 5'd0, e3}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
